// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD      = 4;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE
  } state_e;

  // A session is only accepted for 1..depth words.
  function automatic logic count_ok(input logic [15:0] wc, input int unsigned depth);
    return (wc != '0) && (32'(wc) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface imem_loader_if;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word; last_o flags the 4th byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  // Shifting right lands the first byte in bits [7:0] once the word is complete.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (load) begin
      word_d = {byte_i, word_q[31:8]};
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o = word_q;
  assign last_o = load && !clear && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory, one 32-bit word write per 4 bytes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   word_count,
  input  logic          abort,
  imem_loader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          error
);

  state_e      state_q;
  logic [15:0] remain_q;
  logic [31:0] addr_q;
  logic        ready_q, we_q, busy_q, done_q, error_q;

  logic        accept, abort_act, take, last;
  logic [31:0] word;

  assign accept    = (state_q == ST_IDLE) && start && count_ok(word_count, DEPTH_WORDS);
  assign abort_act = abort && ((state_q == ST_RECV) || (state_q == ST_WRITE));

  // Abort masks the registered strobes combinationally so it wins in its own cycle.
  assign bus.byte_ready = ready_q && !abort_act;
  assign bus.mem_we     = we_q && !abort_act;
  assign take           = bus.byte_valid && bus.byte_ready;

  byte_packer u_packer (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .load   (take),
    .byte_i (bus.byte_data),
    .word_o (word),
    .last_o (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      addr_q   <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q  <= ST_RECV;
            remain_q <= word_count;
            addr_q   <= BASE_ADDR;
            ready_q  <= 1'b1;
            busy_q   <= 1'b1;
          end else if (start) begin
            error_q <= 1'b1;
          end
        end
        ST_RECV: begin
          if (abort) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else if (last) begin
            state_q <= ST_WRITE;
            ready_q <= 1'b0;
            we_q    <= 1'b1;
          end
        end
        ST_WRITE: begin
          we_q <= 1'b0;
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else if (remain_q > 16'd1) begin
            // Address only advances when another word follows, so it never passes the last slot.
            state_q  <= ST_RECV;
            remain_q <= remain_q - 16'd1;
            addr_q   <= addr_q + 32'd4;
            ready_q  <= 1'b1;
          end else begin
            state_q  <= ST_DONE;
            remain_q <= '0;
            done_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized checks of imem_loader against a queue-based write model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] word_count;
  logic        busy, done, error;

  imem_loader_if bus ();

  imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cyc, err_cyc, busy_cyc;
  wr_t act_q[$];
  wr_t exp_q[$];
  logic [7:0] bytes_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_t w;
      w.addr = bus.mem_addr;
      w.data = bus.mem_wdata;
      act_q.push_back(w);
      chk("addr_bound", 32'(bus.mem_addr <= BASE + 32'(4 * (DEPTH - 1))), 32'd1);
    end
    if (done)  done_cyc++;
    if (error) err_cyc++;
    if (busy)  busy_cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    act_q.delete();
    done_cyc = 0;
    err_cyc  = 0;
    busy_cyc = 0;
  endtask

  // Expected writes: word i sits at BASE+4i, byte 4i+k in bits [8k+7:8k].
  function automatic void model(input int nwords);
    exp_q.delete();
    for (int i = 0; i < nwords; i++) begin
      wr_t w;
      w.addr = BASE + 32'(4 * i);
      w.data = {bytes_q[4*i+3], bytes_q[4*i+2], bytes_q[4*i+1], bytes_q[4*i]};
      exp_q.push_back(w);
    end
  endfunction

  task automatic rand_bytes(input int n);
    bytes_q.delete();
    repeat (n) bytes_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic poke();
    start      = 1'($urandom_range(0, 1));
    word_count = 16'($urandom_range(1, DEPTH));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noisy);
    logic ok;
    ok = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (gap) begin
      if (noisy) poke();
      step();
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 64; i++) begin
      if (noisy) poke();
      @(negedge clk);
      ok = bus.byte_ready;
      step();
      if (ok) break;
    end
    chk("byte_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    step();
  endtask

  task automatic begin_session(input int wc);
    start      = 1'b1;
    word_count = 16'(wc);
    step();
    start = 1'b0;
  endtask

  task automatic session(input int wc, input int gmin, input int gmax, input bit noisy);
    clear_mon();
    model(wc);
    begin_session(wc);
    for (int i = 0; i < 4 * wc; i++)
      send_byte(bytes_q[i], $urandom_range(gmax, gmin), noisy);
    bus.byte_valid = 1'b0;
    start          = 1'b0;
    wait_idle();
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk({tag, "_addr"}, act_q[i].addr, exp_q[i].addr);
      chk({tag, "_data"}, act_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b1; word_count = 16'd4;
    bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    step();
    start = 1'b0; abort = 1'b0;
    rst = 1'b0;
    repeat (2) step();

    // Two-word load with continuous bytes.
    bytes_q = '{8'h23, 8'h0e, 8'h80, 8'h00, 8'h13, 8'h04, 8'h01, 8'h02};
    session(2, 0, 0, 1'b0);
    check_writes("cont");
    if (act_q.size() == 2) begin
      chk("cont_w0", act_q[0].data, 32'h00800e23);
      chk("cont_w1", act_q[1].data, 32'h02010413);
      chk("cont_a1", act_q[1].addr, 32'h0000_0004);
    end
    chk("cont_done", 32'(done_cyc), 32'd1);
    chk("cont_busy", 32'(busy_cyc), 32'd11);
    chk("cont_err", 32'(err_cyc), 32'd0);

    // Same stream with 3-cycle gaps.
    session(2, 3, 3, 1'b0);
    check_writes("gap");
    chk("gap_done", 32'(done_cyc), 32'd1);

    // Rejected word counts.
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      begin_session(k == 0 ? 0 : 65);
      repeat (3) step();
      chk("rej_err", 32'(err_cyc), 32'd1);
      chk("rej_busy", 32'(busy_cyc), 32'd0);
      chk("rej_we", 32'(act_q.size()), 32'd0);
    end

    // Abort after two bytes of word 1.
    rand_bytes(8);
    clear_mon();
    model(1);
    begin_session(2);
    for (int i = 0; i < 6; i++) send_byte(bytes_q[i], 0, 1'b0);
    abort = 1'b1;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(bus.byte_ready), 32'd0);
    step();
    abort = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (2) step();
    check_writes("abort");
    chk("abort_err", 32'(err_cyc), 32'd1);
    chk("abort_done", 32'(done_cyc), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rand_bytes(4);
    session(1, 0, 1, 1'b0);
    check_writes("reload");

    // Reset while word 0 is being written.
    rand_bytes(8);
    clear_mon();
    model(1);
    begin_session(2);
    for (int i = 0; i < 4; i++) send_byte(bytes_q[i], 0, 1'b0);
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rstw_we", 32'(bus.mem_we), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_ready", 32'(bus.byte_ready), 32'd0);
    chk("rstw_addr", bus.mem_addr, 32'd0);
    chk("rstw_wdata", bus.mem_wdata, 32'd0);
    step();
    rst = 1'b0;
    repeat (12) step();
    check_writes("rstw");
    chk("rstw_done", 32'(done_cyc), 32'd0);
    chk("rstw_err", 32'(err_cyc), 32'd0);

    // Full-depth load with start noise during the session.
    rand_bytes(4 * DEPTH);
    session(DEPTH, 0, 2, 1'b1);
    check_writes("full");
    if (act_q.size() > 0) chk("full_last_addr", act_q[act_q.size()-1].addr, 32'h0000_00fc);
    chk("full_done", 32'(done_cyc), 32'd1);
    chk("full_err", 32'(err_cyc), 32'd0);

    // Randomized sessions.
    for (int s = 0; s < 6; s++) begin
      int wc;
      wc = $urandom_range(1, 6);
      rand_bytes(4 * wc);
      if (s % 2 == 0) begin
        session(wc, 0, 0, 1'b0);
        chk("rnd_busy", 32'(busy_cyc), 32'(5 * wc + 1));
      end else begin
        session(wc, 0, 3, 1'b1);
      end
      check_writes("rnd");
      chk("rnd_done", 32'(done_cyc), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64: instruction memory capacity in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request a load session.
REQ-006 SHALL have port word_count, input, 16: number of words to load, sampled when start is accepted.
REQ-007 SHALL have port abort, input, 1: cancel the session in progress.
REQ-008 SHALL have port byte_valid, input, 1: byte_data is valid.
REQ-009 SHALL have port byte_data, input, 8: program byte stream, little-endian within each word.
REQ-010 SHALL have port byte_ready, output, 1: loader accepts a byte this cycle.
REQ-011 SHALL have port mem_we, output, 1: instruction memory write strobe.
REQ-012 SHALL have port mem_addr, output, 32: word-aligned byte address of the write.
REQ-013 SHALL have port mem_wdata, output, 32: instruction word to write.
REQ-014 SHALL have port busy, output, 1: session active; the core is held in reset.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when the session completes.
REQ-016 SHALL have port error, output, 1: one-cycle pulse on a rejected start or an abort.

Function
REQ-017 SHALL implement the FSM states IDLE, RECV, WRITE and DONE.
REQ-018 In IDLE, start=1 with 1 <= word_count <= DEPTH_WORDS SHALL latch the count, set the address to BASE_ADDR and the byte index to 0, and go to RECV.
REQ-019 In IDLE, start=1 with word_count=0 or word_count > DEPTH_WORDS SHALL pulse error for 1 cycle and remain in IDLE.
REQ-020 SHALL assert byte_ready only in RECV; a byte transfers exactly on a cycle where byte_valid=1 and byte_ready=1.
REQ-021 SHALL place accepted byte k (k = 0..3) in mem_wdata[8k+7:8k].
REQ-022 On acceptance of byte 3, SHALL go to WRITE on the next cycle.
REQ-023 In WRITE, SHALL assert mem_we=1 for exactly one cycle with mem_addr and mem_wdata stable; byte_ready=0.
REQ-024 After WRITE, SHALL add 4 to the address and decrement the remaining count, then go to RECV if remaining > 0, else DONE.
REQ-025 In DONE, SHALL pulse done for 1 cycle, then return to IDLE.
REQ-026 SHALL hold busy=1 in RECV, WRITE and DONE, and busy=0 in IDLE.
REQ-027 SHALL ignore start while busy=1.
REQ-028 In RECV or WRITE, abort=1 SHALL take priority over a byte transfer or mem_we.
REQ-029 On abort, SHALL suppress mem_we that cycle, pulse error, and return to IDLE next cycle; a partial word is discarded.
REQ-030 SHALL ignore abort in IDLE.
REQ-031 Gaps in byte_valid (idle cycles) SHALL NOT change the assembly state.
REQ-032 The address SHALL never exceed BASE_ADDR + 4*(DEPTH_WORDS-1).
REQ-033 The session latency SHALL be 5 cycles per word under continuous byte_valid, plus 1 DONE cycle.

Reset
REQ-034 rst=1 SHALL force state IDLE and drive byte_ready, mem_we, busy, done and error to 0, and mem_addr and mem_wdata to 0, on the next edge.
REQ-035 rst during a session SHALL discard all progress, with no further mem_we and no done/error pulse.
REQ-036 rst SHALL override start and abort in the same cycle.

Structure
REQ-037 Package imem_loader_pkg SHALL hold the state enum, BYTES_PER_WORD=4 and the default DEPTH_WORDS.
REQ-038 Byte-to-word assembly SHALL be one sub-module, byte_packer (shift register plus 2-bit index, with clear and load inputs); the FSM and address counter SHALL stay in imem_loader.

Verification
REQ-039 Bench SHALL cover: start, word_count=2, continuous bytes 23 0e 80 00 13 04 01 02 -> writes 0x00800e23 @0x00 and 0x02010413 @0x04, then a done pulse, with busy=1 for 11 cycles.
REQ-040 Bench SHALL cover: same stream with 3-cycle byte_valid gaps -> identical writes, no extra mem_we.
REQ-041 Bench SHALL cover: word_count=0 and word_count=65 -> 1-cycle error pulse each, busy stays 0, no mem_we.
REQ-042 Bench SHALL cover: abort after 2 bytes of word 1 -> no write for word 1, error pulse, IDLE; the next start loads again at 0x00.
REQ-043 Bench SHALL cover: rst asserted in WRITE of word 0 -> mem_we=0 next cycle, all outputs 0, no done.
REQ-044 Bench SHALL cover: word_count=64 full load -> last write at 0x0FC, with start pulses during the session ignored.
